edge_detection_stream_router: RTL and testbench
===============================================

// Module: edge_detection_stream_router
// PURPOSE
//  Avalon-ST 1:2 video packet router driven by the edge-detection router control bit.
//  Sits downstream of the router-control PIO: its out_port drives select here.
//  Steers each incoming video packet to the bypass path (out_0) or the edge-detection
//  path (out_1). Path changes take effect only at packet boundaries, so no frame is split.
// PARAMETERS
//  DW       23  data MSB index (24-bit RGB pixel)
//  EW        1  empty MSB index
//  CNT_W    16  width of the dropped-beat counter
// PORTS
//  clk                      in   1     system clock
//  reset                    in   1     synchronous, active-high reset
//  select                   in   1     route control: 0 = bypass (out_0), 1 = edge path (out_1)
//  stream_in_data           in   DW+1  pixel data
//  stream_in_startofpacket  in   1     first beat of packet
//  stream_in_endofpacket    in   1     last beat of packet
//  stream_in_empty          in   EW+1  empty symbols on last beat
//  stream_in_valid          in   1     input beat valid
//  stream_in_ready          out  1     input beat accepted when valid & ready
//  stream_out_0_*           out  -     bypass port: data, startofpacket, endofpacket, empty, valid
//  stream_out_0_ready       in   1     bypass port ready
//  stream_out_1_*           out  -     edge port: data, startofpacket, endofpacket, empty, valid
//  stream_out_1_ready       in   1     edge port ready
//  in_packet                out  1     1 while between an accepted SOP and its EOP
//  dropped_beats            out  CNT_W count of discarded out-of-packet beats, saturating
// BEHAVIOUR
//  - Reset (sync, high): all out valids 0, out data/sop/eop/empty 0, state IDLE,
//    dest 0, select_q 0, dropped_beats 0. Reset mid-packet abandons the packet
//    without asserting EOP; the held beat is discarded.
//  - select is registered once (select_q). select_q is the value used at SOP.
//  - Shared output register {data, sop, eop, empty, valid_r, dest}.
//    stream_out_k_valid = valid_r & (dest == k). Other port's valid held 0.
//    Non-selected port's data/sop/eop/empty pass the register contents;
//    consumers qualify with valid.
//  - accept = stream_in_valid & stream_in_ready.
//    stream_in_ready = ~valid_r | stream_out_<dest>_ready (combinational).
//    Full throughput; latency 1 cycle from accept to out valid.
//  - Output register holds stable while valid_r & ~ready of selected port.
//  - FSM, 2 states:
//    IDLE: accept & sop -> dest <= select_q, load reg; eop also set ? stay IDLE : IN_PKT.
//          accept & ~sop -> beat dropped (no load), dropped_beats += 1 (saturates at all-ones).
//    IN_PKT: accept & ~sop -> load with current dest; eop -> IDLE.
//            accept & sop (missing EOP) -> treat as new packet: dest <= select_q,
//            load, stay IN_PKT unless eop also set.
//  - in_packet = (state == IN_PKT).
//  - select toggling mid-packet has no effect until the next accepted SOP.
//  - Pending beat with old dest and new SOP with new dest: the new beat is accepted only
//    when the old beat drains on its own port. Never reorder, never duplicate.
//  - valid_r clears when the selected port takes the beat and no new beat is accepted
//    in the same cycle.
// TESTING
//  1 select=0, 4-beat pkt (sop beat 0, eop beat 3), both readies=1 -> 4 beats on out_0,
//    1-cycle latency, out_1_valid never 1, in_packet high for beats 1..3.
//  2 select 0->1 on beat 2 of a 6-beat pkt -> whole pkt on out_0. Next pkt entirely on out_1.
//  3 select=1, out_1_ready toggles 1,0,0,1 -> stream_in_ready follows; data and sop held
//    stable while stalled; no beat lost; out_0_valid stays 0.
//  4 3 beats with no sop while IDLE -> none emitted, dropped_beats=3.
//    Preset to 16'hFFFF plus 1 drop -> stays 16'hFFFF.
//  5 SOP arrives mid-packet (no EOP) with select flipped -> new pkt routed to new port;
//    old port's last beat drained first; in_packet stays 1.
//  6 reset asserted at beat 2 of a packet -> next cycle all valids 0, state IDLE.
//    Next SOP routed by current select_q.
//    Single-beat pkt (sop & eop) -> one beat out, in_packet never 1.

Source files
------------

// File: rtl/edge_detection_stream_router.sv
// rtl/edge_detection_stream_router.sv - 1:2 packet router steering video packets to bypass or edge-detection path
// Route changes are latched only at an accepted SOP so a packet is never split between ports.
module edge_detection_stream_router #(
  parameter int DW    = 23,
  parameter int EW    = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,

  input  logic [DW:0]      stream_in_data,
  input  logic             stream_in_startofpacket,
  input  logic             stream_in_endofpacket,
  input  logic [EW:0]      stream_in_empty,
  input  logic             stream_in_valid,
  output logic             stream_in_ready,

  output logic [DW:0]      stream_out_0_data,
  output logic             stream_out_0_startofpacket,
  output logic             stream_out_0_endofpacket,
  output logic [EW:0]      stream_out_0_empty,
  output logic             stream_out_0_valid,
  input  logic             stream_out_0_ready,

  output logic [DW:0]      stream_out_1_data,
  output logic             stream_out_1_startofpacket,
  output logic             stream_out_1_endofpacket,
  output logic [EW:0]      stream_out_1_empty,
  output logic             stream_out_1_valid,
  input  logic             stream_out_1_ready,

  output logic             in_packet,
  output logic [CNT_W-1:0] dropped_beats
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             dest_q, dest_d;
  logic             select_q;
  logic [DW:0]      data_q, data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [EW:0]      empty_q, empty_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;

  logic dest_ready;
  logic accept;
  logic load;
  logic drop;

  // Backpressure comes only from the port currently holding the beat, so a
  // new SOP headed elsewhere waits until the old beat drains on its own port.
  assign dest_ready      = dest_q ? stream_out_1_ready : stream_out_0_ready;
  assign stream_in_ready = ~valid_q | dest_ready;
  assign accept          = stream_in_valid & stream_in_ready;
  assign load            = accept & (stream_in_startofpacket | (state_q == IN_PKT));
  assign drop            = accept & ~stream_in_startofpacket & (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    empty_d   = empty_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;

    if (valid_q & dest_ready) begin
      valid_d = 1'b0;
    end

    if (load) begin
      data_d  = stream_in_data;
      sop_d   = stream_in_startofpacket;
      eop_d   = stream_in_endofpacket;
      empty_d = stream_in_empty;
      valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept & stream_in_startofpacket) begin
          dest_d  = select_q;
          state_d = stream_in_endofpacket ? IDLE : IN_PKT;
        end
      end
      IN_PKT: begin
        if (accept) begin
          // A SOP without a preceding EOP restarts routing with the current select.
          if (stream_in_startofpacket) begin
            dest_d = select_q;
          end
          state_d = stream_in_endofpacket ? IDLE : IN_PKT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop & ~(&dropped_q)) begin
      dropped_d = dropped_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dest_q    <= 1'b0;
      select_q  <= 1'b0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
      valid_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      select_q  <= select;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      empty_q   <= empty_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign stream_out_0_data          = data_q;
  assign stream_out_0_startofpacket = sop_q;
  assign stream_out_0_endofpacket   = eop_q;
  assign stream_out_0_empty         = empty_q;
  assign stream_out_0_valid         = valid_q & ~dest_q;

  assign stream_out_1_data          = data_q;
  assign stream_out_1_startofpacket = sop_q;
  assign stream_out_1_endofpacket   = eop_q;
  assign stream_out_1_empty         = empty_q;
  assign stream_out_1_valid         = valid_q & dest_q;

  assign in_packet     = (state_q == IN_PKT);
  assign dropped_beats = dropped_q;

endmodule

// File: tb/tb_edge_detection_stream_router.sv
// tb/tb_edge_detection_stream_router.sv - scoreboard bench for edge_detection_stream_router
module tb_edge_detection_stream_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        select;
  logic [23:0] in_data;
  logic        in_sop, in_eop, in_valid;
  logic [1:0]  in_empty;
  logic        in_ready;
  logic [23:0] o0_data, o1_data;
  logic        o0_sop, o0_eop, o0_valid, o0_ready;
  logic        o1_sop, o1_eop, o1_valid, o1_ready;
  logic [1:0]  o0_empty, o1_empty;
  logic        in_packet;
  logic [15:0] dropped;

  logic        s_in_ready, s_in_packet;
  logic [23:0] s_o0_data, s_o1_data;
  logic        s_o0_sop, s_o0_eop, s_o0_valid, s_o1_sop, s_o1_eop, s_o1_valid;
  logic [1:0]  s_o0_empty, s_o1_empty;
  logic [3:0]  s_dropped;

  int checks = 0;
  int errors = 0;
  logic [27:0] q0[$];
  logic [27:0] q1[$];
  int n0 = 0, n1 = 0, v1_cnt = 0;
  logic sel_q_m = 1'b0;
  logic dest_m  = 1'b0;
  logic st_m    = 1'b0;
  int drops_m   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) sel_q_m <= reset ? 1'b0 : select;

  edge_detection_stream_router dut (
    .clk(clk), .reset(reset), .select(select),
    .stream_in_data(in_data), .stream_in_startofpacket(in_sop),
    .stream_in_endofpacket(in_eop), .stream_in_empty(in_empty),
    .stream_in_valid(in_valid), .stream_in_ready(in_ready),
    .stream_out_0_data(o0_data), .stream_out_0_startofpacket(o0_sop),
    .stream_out_0_endofpacket(o0_eop), .stream_out_0_empty(o0_empty),
    .stream_out_0_valid(o0_valid), .stream_out_0_ready(o0_ready),
    .stream_out_1_data(o1_data), .stream_out_1_startofpacket(o1_sop),
    .stream_out_1_endofpacket(o1_eop), .stream_out_1_empty(o1_empty),
    .stream_out_1_valid(o1_valid), .stream_out_1_ready(o1_ready),
    .in_packet(in_packet), .dropped_beats(dropped)
  );

  edge_detection_stream_router #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .select(select),
    .stream_in_data(in_data), .stream_in_startofpacket(in_sop),
    .stream_in_endofpacket(in_eop), .stream_in_empty(in_empty),
    .stream_in_valid(in_valid), .stream_in_ready(s_in_ready),
    .stream_out_0_data(s_o0_data), .stream_out_0_startofpacket(s_o0_sop),
    .stream_out_0_endofpacket(s_o0_eop), .stream_out_0_empty(s_o0_empty),
    .stream_out_0_valid(s_o0_valid), .stream_out_0_ready(1'b1),
    .stream_out_1_data(s_o1_data), .stream_out_1_startofpacket(s_o1_sop),
    .stream_out_1_endofpacket(s_o1_eop), .stream_out_1_empty(s_o1_empty),
    .stream_out_1_valid(s_o1_valid), .stream_out_1_ready(1'b1),
    .in_packet(s_in_packet), .dropped_beats(s_dropped)
  );

  task automatic monitor();
    logic [27:0] exp_b;
    forever begin
      @(negedge clk);
      if (o1_valid) v1_cnt++;
      if (!reset && o0_valid && o0_ready) begin
        checks++;
        n0++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0_unexpected got=%h expected none", {o0_data, o0_sop, o0_eop, o0_empty});
        end else begin
          exp_b = q0.pop_front();
          if ({o0_data, o0_sop, o0_eop, o0_empty} !== exp_b) begin
            errors++;
            $display("FAIL out0_beat got=%h expected=%h", {o0_data, o0_sop, o0_eop, o0_empty}, exp_b);
          end
        end
      end
      if (!reset && o1_valid && o1_ready) begin
        checks++;
        n1++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1_unexpected got=%h expected none", {o1_data, o1_sop, o1_eop, o1_empty});
        end else begin
          exp_b = q1.pop_front();
          if ({o1_data, o1_sop, o1_eop, o1_empty} !== exp_b) begin
            errors++;
            $display("FAIL out1_beat got=%h expected=%h", {o1_data, o1_sop, o1_eop, o1_empty}, exp_b);
          end
        end
      end
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic s, input logic e, input logic [1:0] em);
    logic done;
    done     = 1'b0;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_empty = em;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1'b1;
        if (s) begin
          dest_m = sel_q_m;
          st_m   = !e;
          if (dest_m) q1.push_back({d, s, e, em}); else q0.push_back({d, s, e, em});
        end else if (st_m) begin
          if (dest_m) q1.push_back({d, s, e, em}); else q0.push_back({d, s, e, em});
          if (e) st_m = 1'b0;
        end else begin
          drops_m++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout data=%h ready=%b expected accept", d, in_ready);
    end
  endtask

  task automatic wait_drain();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o0_valid, o1_valid, in_packet, o0_data, o0_sop, o0_eop, o0_empty} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v0=%b v1=%b pkt=%b data=%h expected all 0", o0_valid, o1_valid, in_packet, o0_data);
    end
    checks++;
    if (dropped !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_counters dropped=%h ready=%b expected 0 1", dropped, in_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) send_beat(24'h100 + 24'(i), 1'b0, 1'b0, 2'd0);
    wait_drain();
    checks++;
    if (dropped !== 16'd3 || dropped !== 16'(drops_m)) begin
      errors++;
      $display("FAIL drop_count got=%0d expected=3", dropped);
    end
    for (int i = 0; i < 12; i++) send_beat(24'h200 + 24'(i), 1'b0, (i % 2) == 1, 2'd1);
    checks++;
    if (s_dropped !== 4'hF) begin
      errors++;
      $display("FAIL drop_reach_max got=%h expected=f", s_dropped);
    end
    send_beat(24'h2FF, 1'b0, 1'b0, 2'd0);
    checks++;
    if (s_dropped !== 4'hF || dropped !== 16'd16) begin
      errors++;
      $display("FAIL drop_saturate small=%h big=%0d expected f 16", s_dropped, dropped);
    end
    checks++;
    if (n0 != 0 || n1 != 0) begin
      errors++;
      $display("FAIL drop_no_output n0=%0d n1=%0d expected 0 0", n0, n1);
    end
  endtask

  task automatic test_basic();
    int v1_start;
    logic [23:0] d;
    select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    v1_start = v1_cnt;
    for (int i = 0; i < 4; i++) begin
      d = 24'hA00000 + 24'(i);
      send_beat(d, i == 0, i == 3, (i == 3) ? 2'd2 : 2'd0);
      checks++;
      if (o0_valid !== 1'b1 || o0_data !== d) begin
        errors++;
        $display("FAIL basic_latency beat=%0d v=%b data=%h expected 1 %h", i, o0_valid, o0_data, d);
      end
      checks++;
      if (in_packet !== (i < 3)) begin
        errors++;
        $display("FAIL basic_in_packet beat=%0d got=%b expected=%b", i, in_packet, i < 3);
      end
    end
    wait_drain();
    checks++;
    if (v1_cnt != v1_start) begin
      errors++;
      $display("FAIL basic_out1_quiet got=%0d expected 0", v1_cnt - v1_start);
    end
  endtask

  task automatic test_select_mid();
    int n0s, n1s;
    n0s = n0;
    n1s = n1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) select = 1'b1;
      send_beat(24'hB00000 + 24'(i), i == 0, i == 5, 2'd0);
    end
    wait_drain();
    checks++;
    if (n0 - n0s != 6 || n1 != n1s) begin
      errors++;
      $display("FAIL select_mid_pkt0 n0=%0d n1=%0d expected 6 0", n0 - n0s, n1 - n1s);
    end
    for (int i = 0; i < 4; i++) send_beat(24'hC00000 + 24'(i), i == 0, i == 3, 2'd3);
    wait_drain();
    checks++;
    if (n1 - n1s != 4 || n0 - n0s != 6) begin
      errors++;
      $display("FAIL select_mid_pkt1 n0=%0d n1=%0d expected 6 4", n0 - n0s, n1 - n1s);
    end
  endtask

  task automatic test_stall();
    logic [1:0] pat [8];
    int stalls;
    int n0s;
    pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    stalls = 0;
    n0s = n0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(24'hD00000 + 24'(i), i == 0, i == 3, 2'd0);
      end
      begin
        logic prev_stall;
        logic [24:0] held;
        prev_stall = 1'b0;
        held = '0;
        for (int i = 0; i < 8; i++) begin
          o1_ready = pat[i][0];
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if ({o1_data, o1_sop} !== held || o1_valid !== 1'b1) begin
              errors++;
              $display("FAIL stall_hold got=%h v=%b expected=%h", {o1_data, o1_sop}, o1_valid, held);
            end
          end
          prev_stall = o1_valid && !o1_ready;
          if (prev_stall) begin
            stalls++;
            held = {o1_data, o1_sop};
            checks++;
            if (in_ready !== 1'b0) begin
              errors++;
              $display("FAIL stall_ready got=%b expected=0", in_ready);
            end
          end
          @(posedge clk);
          #1;
        end
        o1_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (stalls != 2 || n0 != n0s) begin
      errors++;
      $display("FAIL stall_summary stalls=%0d out0=%0d expected 2 0", stalls, n0 - n0s);
    end
  endtask

  task automatic test_sop_mid();
    select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_beat(24'hE00000 + 24'(i), i == 0, 1'b0, 2'd0);
    o0_ready = 1'b0;
    select = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || o0_valid !== 1'b1 || o1_valid !== 1'b0) begin
      errors++;
      $display("FAIL sop_mid_pending ready=%b v0=%b v1=%b expected 0 1 0", in_ready, o0_valid, o1_valid);
    end
    @(posedge clk);
    #1;
    fork
      send_beat(24'hF00000, 1'b1, 1'b0, 2'd0);
      begin
        repeat (3) @(posedge clk);
        #1;
        o0_ready = 1'b1;
      end
    join
    checks++;
    if (q0.size() != 0 || o1_valid !== 1'b1 || o1_data !== 24'hF00000 || in_packet !== 1'b1) begin
      errors++;
      $display("FAIL sop_mid_route q0=%0d v1=%b data=%h pkt=%b expected 0 1 f00000 1", q0.size(), o1_valid, o1_data, in_packet);
    end
    send_beat(24'hF00001, 1'b0, 1'b0, 2'd0);
    send_beat(24'hF00002, 1'b0, 1'b1, 2'd1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) send_beat(24'h700000 + 24'(i), i == 0, 1'b0, 2'd0);
    in_data  = 24'h700002;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_valid = 1'b1;
    reset    = 1'b1;
    select   = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (o0_valid !== 1'b0 || o1_valid !== 1'b0 || in_packet !== 1'b0 || dropped !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid v0=%b v1=%b pkt=%b dropped=%0d expected 0 0 0 0", o0_valid, o1_valid, in_packet, dropped);
    end
    q0.delete();
    q1.delete();
    st_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(24'h123456, 1'b1, 1'b1, 2'd2);
    checks++;
    if (in_packet !== 1'b0 || o0_valid !== 1'b1 || o0_data !== 24'h123456 || o1_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_beat pkt=%b v0=%b data=%h v1=%b expected 0 1 123456 0", in_packet, o0_valid, o0_data, o1_valid);
    end
    @(negedge clk);
    checks++;
    if (in_packet !== 1'b0) begin
      errors++;
      $display("FAIL single_beat_pkt_later got=%b expected=0", in_packet);
    end
    wait_drain();
  endtask

  initial begin
    reset    = 1'b1;
    select   = 1'b0;
    in_data  = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_empty = '0;
    in_valid = 1'b0;
    o0_ready = 1'b1;
    o1_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_drop();
    test_basic();
    test_select_mid();
    test_stall();
    test_sop_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
